// File: rtl/vc_plane_scheduler.sv
// Shares one link among VC router planes: round-robin wormhole arbitration with per-plane credits.
// Latency: grant registered one cycle after request; one bubble cycle between packets.
// Backpressure: link_ready and zero credit stall the locked plane without breaking the lock.
module vc_plane_scheduler #(
    parameter int VC           = 4,
    parameter int FIFO_DEPTH   = 32,
    parameter int CREDIT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [VC-1:0] plane_valid,
    input  logic [VC-1:0] plane_tail,
    output logic [VC-1:0] plane_ready,
    output logic          link_valid,
    input  logic          link_ready,
    input  logic [VC-1:0] credit_return,
    output logic [VC:0]   VCPlaneSelector,
    output logic          credit_overflow
);

    localparam int GW = (VC > 1) ? $clog2(VC) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [VC:0]             sel_q, sel_d;
    logic [CREDIT_WIDTH-1:0] credit_q [VC];
    logic                    ovf_q;

    logic [VC-1:0]           elig;
    logic                    found;
    logic [GW-1:0]           winner;
    logic                    fire;

    always_comb begin
        for (int p = 0; p < VC; p++) begin
            elig[p] = plane_valid[p] && (credit_q[p] != '0);
        end
    end

    // Rotating scan: first eligible plane at or after ptr, wrapping past VC-1.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < VC; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= VC) begin
                idx = idx - VC;
            end
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        link_valid  = 1'b0;
        plane_ready = '0;
        if (state_q == LOCKED) begin
            link_valid = plane_valid[g_q] && (credit_q[g_q] != '0);
        end
        fire = link_valid && link_ready;
        if (fire) begin
            plane_ready[g_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                sel_d     = '0;
                sel_d[VC] = 1'b1;
                if (found) begin
                    state_d       = LOCKED;
                    g_d           = winner;
                    ptr_d         = (winner == GW'(VC - 1)) ? '0 : winner + 1'b1;
                    sel_d         = '0;
                    sel_d[winner] = 1'b1;
                end
            end
            LOCKED: begin
                // Only the tail transfer releases the link; stalls keep the lock.
                if (fire && plane_tail[g_q]) begin
                    state_d   = IDLE;
                    sel_d     = '0;
                    sel_d[VC] = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                sel_d     = '0;
                sel_d[VC] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            sel_q   <= {1'b1, {VC{1'b0}}};
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // A return arriving at a full counter saturates and latches the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < VC; p++) begin
                credit_q[p] <= CREDIT_WIDTH'(FIFO_DEPTH);
            end
            ovf_q <= 1'b0;
        end else begin
            for (int p = 0; p < VC; p++) begin
                if (credit_return[p] && !plane_ready[p]) begin
                    if (credit_q[p] == CREDIT_WIDTH'(FIFO_DEPTH)) begin
                        ovf_q <= 1'b1;
                    end else begin
                        credit_q[p] <= credit_q[p] + 1'b1;
                    end
                end else if (plane_ready[p] && !credit_return[p]) begin
                    credit_q[p] <= credit_q[p] - 1'b1;
                end
            end
        end
    end

    assign VCPlaneSelector = sel_q;
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Directed bench for vc_plane_scheduler: a 32-deep instance and a 2-deep instance share clock and reset.
module tb_vc_plane_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] pv = '0, pt = '0, cr = '0, pr;
    logic       lr = 1'b1, lv, ovf;
    logic [4:0] sel;

    logic [3:0] pv2 = '0, pt2 = '0, cr2 = '0, pr2;
    logic       lr2 = 1'b1, lv2, ovf2;
    logic [4:0] sel2;

    vc_plane_scheduler #(.VC(4), .FIFO_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .plane_valid(pv), .plane_tail(pt), .plane_ready(pr),
        .link_valid(lv), .link_ready(lr), .credit_return(cr),
        .VCPlaneSelector(sel), .credit_overflow(ovf)
    );

    vc_plane_scheduler #(.VC(4), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .plane_valid(pv2), .plane_tail(pt2), .plane_ready(pr2),
        .link_valid(lv2), .link_ready(lr2), .credit_return(cr2),
        .VCPlaneSelector(sel2), .credit_overflow(ovf2)
    );

    typedef struct {
        logic [3:0] pv;
        logic [3:0] pt;
        logic       lr;
        logic [3:0] cr;
        logic [4:0] sel;
        logic       lv;
        logic [3:0] pr;
    } vec_t;

    vec_t tbl [13];
    int   n_pass  = 0;
    int   n_total = 0;
    int   fires;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pv = '0; pt = '0; cr = '0; lr = 1'b1;
        pv2 = '0; pt2 = '0; cr2 = '0; lr2 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Planes 0 and 2 send 3-flit packets together, then planes 3 and 0 probe the RR pointer.
        tbl[0]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 5'b10000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 5'b00001, 1'b1, 4'b0001};
        tbl[2]  = '{4'b0101, 4'b0000, 1'b1, 4'b0000, 5'b00001, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0101, 4'b0001, 1'b1, 4'b0000, 5'b00001, 1'b1, 4'b0001};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 5'b10000, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 5'b00100, 1'b1, 4'b0100};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 5'b00100, 1'b1, 4'b0100};
        tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 5'b00100, 1'b1, 4'b0100};
        tbl[8]  = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 5'b10000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 5'b01000, 1'b1, 4'b1000};
        tbl[10] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 5'b10000, 1'b0, 4'b0000};
        tbl[11] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 5'b00001, 1'b1, 4'b0001};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 5'b10000, 1'b0, 4'b0000};

        #1;
        do_reset();

        // Reset state and quiet idle.
        settle();
        check("rst_sel", 32'(sel), 32'h10);
        check("rst_lv", 32'(lv), 32'h0);
        check("rst_pr", 32'(pr), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("idle_sel", 32'(sel), 32'h10);
            check("idle_lv", 32'(lv), 32'h0);
        end
        tick();

        for (int i = 0; i < 13; i++) begin
            pv = tbl[i].pv; pt = tbl[i].pt; lr = tbl[i].lr; cr = tbl[i].cr;
            settle();
            check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            check($sformatf("tbl%0d_lv", i), 32'(lv), 32'(tbl[i].lv));
            check($sformatf("tbl%0d_pr", i), 32'(pr), 32'(tbl[i].pr));
            tick();
        end

        // Depth-2 plane 1, 4-flit packet: stalls on zero credit, one return buys one flit.
        pv2 = 4'b0010; pt2 = '0;
        settle(); check("c_idle", 32'(sel2), 32'h10);
        tick(); settle(); check("c_f1", 32'(pr2), 32'h2);
        tick(); settle(); check("c_f2", 32'(pr2), 32'h2);
        tick(); settle();
        check("c_stall_lv", 32'(lv2), 32'h0);
        check("c_stall_pr", 32'(pr2), 32'h0);
        check("c_stall_sel", 32'(sel2), 32'h02);
        cr2 = 4'b0010;
        tick(); cr2 = '0; settle(); check("c_f3", 32'(pr2), 32'h2);
        tick(); settle();
        check("c_stall2_lv", 32'(lv2), 32'h0);
        check("c_stall2_sel", 32'(sel2), 32'h02);
        cr2 = 4'b0010;
        tick(); cr2 = '0; pt2 = 4'b0010; settle(); check("c_tail", 32'(pr2), 32'h2);
        tick(); pv2 = '0; pt2 = '0; settle(); check("c_release", 32'(sel2), 32'h10);

        // Depth-2 plane 0: return and consume in the same cycle leaves the count at 2.
        pv2 = 4'b0001;
        tick(); cr2 = 4'b0001; settle(); check("s_fire_ret", 32'(pr2), 32'h1);
        tick(); cr2 = '0; settle(); check("s_f2", 32'(pr2), 32'h1);
        tick(); settle(); check("s_f3", 32'(pr2), 32'h1);
        tick(); settle(); check("s_empty", 32'(lv2), 32'h0);
        cr2 = 4'b0001;
        tick(); cr2 = '0; pt2 = 4'b0001; settle(); check("s_tail", 32'(pr2), 32'h1);
        tick(); pv2 = '0; pt2 = '0; settle(); check("s_release", 32'(sel2), 32'h10);

        // Depth-2 plane 1 refilled to exactly full: no overflow; one more return overflows.
        cr2 = 4'b0010;
        tick(); tick(); cr2 = '0; settle(); check("o2_full_ok", 32'(ovf2), 32'h0);
        cr2 = 4'b0010;
        tick(); cr2 = '0; settle(); check("o2_set", 32'(ovf2), 32'h1);
        tick(); tick(); settle(); check("o2_sticky", 32'(ovf2), 32'h1);
        tick();

        // Depth-32 plane 0: 27 flits reach credit 5, return+consume holds 5, then 5 more fire.
        do_reset();
        pv = 4'b0001; pt = '0;
        tick();
        fires = 0;
        for (int i = 0; i < 27; i++) begin
            settle();
            if (pr == 4'b0001) fires++;
            tick();
        end
        check("d_27_fires", 32'(fires), 32'd27);
        cr = 4'b0001;
        settle(); check("d_fire_ret", 32'(pr), 32'h1);
        tick(); cr = '0;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (pr == 4'b0001) fires++;
            tick();
        end
        check("d_last5", 32'(fires), 32'd5);
        settle();
        check("d_starved_lv", 32'(lv), 32'h0);
        check("d_starved_sel", 32'(sel), 32'h01);
        cr = 4'b0001;
        tick(); cr = '0; pt = 4'b0001; settle(); check("d_tail", 32'(pr), 32'h1);
        tick(); pv = '0; pt = '0; settle();
        check("d_release", 32'(sel), 32'h10);
        check("d_no_ovf", 32'(ovf), 32'h0);
        cr = 4'b0010;
        tick(); cr = '0; settle(); check("d_ovf_set", 32'(ovf), 32'h1);
        tick(); tick(); tick(); settle(); check("d_ovf_sticky", 32'(ovf), 32'h1);
        tick();

        // All planes request single-flit packets: grants 0,1,2,3,0 two cycles apart.
        do_reset();
        pv = 4'b1111; pt = 4'b1111;
        for (int k = 0; k < 11; k++) begin
            logic [4:0] esel;
            logic [3:0] epr;
            esel = 5'b10000;
            epr  = 4'b0000;
            if (k % 2 == 1) begin
                esel = 5'(1 << (((k - 1) / 2) % 4));
                epr  = 4'(1 << (((k - 1) / 2) % 4));
            end
            settle();
            check($sformatf("rr%0d_sel", k), 32'(sel), 32'(esel));
            check($sformatf("rr%0d_pr", k), 32'(pr), 32'(epr));
            tick();
        end
        lr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_sel", 32'(sel), 32'h02);
            check("hold_lv", 32'(lv), 32'h1);
            check("hold_pr", 32'(pr), 32'h0);
            tick();
        end
        lr = 1'b1;
        settle(); check("hold_fire", 32'(pr), 32'h2);
        tick(); settle(); check("hold_release", 32'(sel), 32'h10);
        tick();

        // Depth-2 plane 3: drain credits mid-packet, reset, credits and lock come back clean.
        do_reset();
        pv2 = 4'b1000; pt2 = '0;
        tick(); settle(); check("f_f1", 32'(pr2), 32'h8);
        tick(); settle(); check("f_f2", 32'(pr2), 32'h8);
        tick(); settle(); check("f_drained", 32'(lv2), 32'h0);
        rst = 1'b1;
        tick(); settle();
        check("f_rst_sel", 32'(sel2), 32'h10);
        check("f_rst_lv", 32'(lv2), 32'h0);
        check("f_rst_pr", 32'(pr2), 32'h0);
        rst = 1'b0;
        tick(); settle(); check("f_regrant", 32'(sel2), 32'h08);
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (pr2 == 4'b1000) fires++;
            tick();
        end
        check("f_credits_restored", 32'(fires), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
